div_unit: RTL and testbench

Multi-cycle RV32M divide/remainder unit, the counterpart of the combinational `mul` block: executes DIV, DIVU, REM and REMU selected by the same 6-bit `ALUCtrl` encoding. It sits beside the ALU in the execute stage. Control logic stalls the pipeline while `busy` is high and captures `result` when `done` pulses. It uses an iterative restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit_pkg.sv | 31 +++
 rtl/div_unit_step.sv | 20 ++
 rtl/div_unit.sv | 113 +++++++++++
 tb/tb_div_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared ALU operation codes, divider FSM states and op-decode helpers.
package div_unit_pkg;
    localparam int XLEN = 32;

    localparam logic [5:0] ALU_MUL    = 6'h18;
    localparam logic [5:0] ALU_MULH   = 6'h19;
    localparam logic [5:0] ALU_MULHSU = 6'h1A;
    localparam logic [5:0] ALU_MULHU  = 6'h1B;
    localparam logic [5:0] ALU_DIV    = 6'h1C;
    localparam logic [5:0] ALU_DIVU   = 6'h1D;
    localparam logic [5:0] ALU_REM    = 6'h1E;
    localparam logic [5:0] ALU_REMU   = 6'h1F;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input logic [5:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction
endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the dividend MSB, trial-subtract the divisor.
module div_step
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            msb_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Keep the remainder's top bit: unsigned divisors near 2^32 need the full XLEN+1 bits.
    // Since rem < divisor, diff[XLEN] is a valid sign bit for the trial subtraction.
    assign shifted = {rem_i, msb_i};
    assign diff    = shifted - {1'b0, dvs_i};
    assign q_o     = ~diff[XLEN];
    assign rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU, 32 RUN cycles then a one-cycle done pulse.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit
    import div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [5:0]      ALUCtrl,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    div_state_e      state_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] rem_q, dvd_q, dvs_q, spec_res_q, result_q;
    logic            rem_op_q, sa_q, sb_q, spec_q, busy_q, done_q;

    logic            accept_d, sgn_d, sa_d, sb_d, div0_d, ovf_d, spec_d;
    logic [XLEN-1:0] mag_a_d, mag_b_d, spec_res_d;
    logic [XLEN-1:0] step_rem, q_fin, q_sgn, r_sgn, final_d;
    logic            step_q;

    assign accept_d   = start && is_div_op(ALUCtrl) && (state_q != DIV_RUN);
    assign sgn_d      = is_signed_op(ALUCtrl);
    assign sa_d       = sgn_d & A[XLEN-1];
    assign sb_d       = sgn_d & B[XLEN-1];
    assign mag_a_d    = sa_d ? -A : A;
    assign mag_b_d    = sb_d ? -B : B;
    assign div0_d     = (B == '0);
    assign ovf_d      = sgn_d && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign spec_d     = div0_d || ovf_d;
    assign spec_res_d = div0_d ? (is_rem_op(ALUCtrl) ? A : 32'hFFFF_FFFF)
                               : (is_rem_op(ALUCtrl) ? 32'h0 : 32'h8000_0000);

    div_step u_step (
        .rem_i (rem_q),
        .msb_i (dvd_q[XLEN-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Quotient bits shift into the low end of the dividend register as it empties.
    assign q_fin   = {dvd_q[XLEN-2:0], step_q};
    assign q_sgn   = (sa_q ^ sb_q) ? -q_fin : q_fin;
    assign r_sgn   = sa_q ? -step_rem : step_rem;
    assign final_d = spec_q ? spec_res_q : (rem_op_q ? r_sgn : q_sgn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            spec_res_q <= '0;
            result_q   <= '0;
            rem_op_q   <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            spec_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DIV_RUN: begin
                    rem_q <= step_rem;
                    dvd_q <= q_fin;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= DIV_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= final_d;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    if (accept_d) begin
                        rem_op_q   <= is_rem_op(ALUCtrl);
                        sa_q       <= sa_d;
                        sb_q       <= sb_d;
                        dvd_q      <= mag_a_d;
                        dvs_q      <= mag_b_d;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        spec_q     <= spec_d;
                        spec_res_q <= spec_res_d;
`ifdef DIV_EARLY_OUT_EN
                        if (spec_d) begin
                            state_q  <= DIV_DONE;
                            done_q   <= 1'b1;
                            result_q <= spec_res_d;
                        end else
`endif
                        begin
                            state_q <= DIV_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: results, done latency, busy window and robustness cases.
module tb_div_unit;
    import div_unit_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int NORM_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [5:0]  ALUCtrl = '0;
    logic        busy, done;
    logic [31:0] result;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .ALUCtrl (ALUCtrl),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // Call at a negedge; returns just after the sampling posedge (edge 0).
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] exp);
        ALUCtrl = op; A = a; B = b; start = 1'b1;
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int busy_cnt = 0;
        int done_cyc = 0;
        logic [31:0] exp;
        for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                chk_cnt++;
                if (result !== exp) $display("FAIL %s result: got %h want %h", name, result, exp);
                else pass_cnt++;
                chk_cnt++;
                if (cyc != exp_lat) $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, exp_lat);
                else pass_cnt++;
                chk_cnt++;
                if (busy_cnt != exp_lat - 1 || busy !== 1'b0)
                    $display("FAIL %s busy_window: got %0d busy cycles (busy=%b at done) want %0d", name, busy_cnt, busy, exp_lat - 1);
                else pass_cnt++;
            end
        end
        if (done_cyc == 0) begin
            chk_cnt++;
            $display("FAIL %s timeout: got no done want done at cycle %0d", name, exp_lat);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({busy, done, result} !== 34'h0) $display("FAIL reset_state: got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({busy, done, result} !== 34'h0) $display("FAIL post_reset_idle: got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        issue(ALU_DIV, 32'd20, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFA);
        wait_done("div_20_m3", NORM_LAT);
        @(negedge clk);
        issue(ALU_REM, 32'hFFFF_FFEC, 32'd3, 1, 32'hFFFF_FFFE);
        wait_done("rem_m20_3", NORM_LAT);
        @(negedge clk);
        issue(ALU_REMU, 32'hFFFF_FFEC, 32'd3, 1, 32'h0000_0002);
        wait_done("remu_m20_3", NORM_LAT);
        @(negedge clk);
        issue(ALU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 32'h0000_0001);
        wait_done("divu_big_divisor", NORM_LAT);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(ALU_DIVU, 32'hFFFF_FFFF, 32'd2, 1, 32'h7FFF_FFFF);
        wait_done("divu_max_2", NORM_LAT);
        issue(ALU_REMU, 32'hFFFF_FFFF, 32'd2, 1, 32'h0000_0001);
        wait_done("remu_b2b", NORM_LAT);
    endtask

    task automatic test_special();
        @(negedge clk);
        issue(ALU_DIV, 32'd7, 32'd0, 1, 32'hFFFF_FFFF);
        wait_done("div_by_zero", SPEC_LAT);
        @(negedge clk);
        issue(ALU_REM, 32'd7, 32'd0, 1, 32'h0000_0007);
        wait_done("rem_by_zero", SPEC_LAT);
        @(negedge clk);
        issue(ALU_DIVU, 32'd9, 32'd0, 1, 32'hFFFF_FFFF);
        wait_done("divu_by_zero", SPEC_LAT);
        @(negedge clk);
        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        wait_done("div_overflow", SPEC_LAT);
        @(negedge clk);
        issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
        wait_done("rem_overflow", SPEC_LAT);
    endtask

    task automatic test_start_in_run();
        int ndone = 0;
        logic [31:0] exp;
        @(negedge clk);
        issue(ALU_DIV, 32'd100, 32'd7, 1, 32'd14);
        repeat (5) @(negedge clk);
        issue(ALU_DIVU, 32'd9, 32'd3, 0, 32'h0);
        for (int cyc = 6; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                chk_cnt++;
                if (result !== exp || cyc != NORM_LAT)
                    $display("FAIL start_in_run_result: got %h at cycle %0d want %h at cycle %0d", result, cyc, exp, NORM_LAT);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (ndone != 1) $display("FAIL start_in_run_done_count: got %0d want 1", ndone);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int act = 0;
        @(negedge clk);
        issue(ALU_DIV, 32'd20, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFA);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({busy, done, result} !== 34'h0) $display("FAIL reset_mid_op: got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        else pass_cnt++;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) act++;
        end
        chk_cnt++;
        if (act != 0) $display("FAIL reset_mid_op_quiet: got %0d active cycles want 0", act);
        else pass_cnt++;
    endtask

    task automatic test_invalid_op();
        int act = 0;
        issue(ALU_MUL, 32'd7, 32'd3, 0, 32'h0);
        repeat (40) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) act++;
        end
        chk_cnt++;
        if (act != 0) $display("FAIL mul_ignored: got %0d active cycles want 0", act);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_signed();
        test_back_to_back();
        test_special();
        test_start_in_run();
        test_reset_mid_op();
        test_invalid_op();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
